// File: rtl/qspi_rd_master_if.sv
// Host-side request/response bundle of the QSPI read initiator.
// The master modport is the requester; the slave modport is the qspi_rd_master itself.
interface qspi_rd_master_if #(
    parameter int LEN_W = 8
) ();
    logic             req_valid;
    logic             req_ready;
    logic [23:0]      req_addr;
    logic [LEN_W-1:0] req_len;
    logic             busy;
    logic             done;
    logic [7:0]       rd_byte;
    logic             rd_byte_valid;

    modport master (
        output req_valid, req_addr, req_len,
        input  req_ready, busy, done, rd_byte, rd_byte_valid
    );

    modport slave (
        input  req_valid, req_addr, req_len,
        output req_ready, busy, done, rd_byte, rd_byte_valid
    );
endinterface

// File: rtl/qspi_rd_master.sv
// Single-lane SPI fast-read initiator: command, 24-bit address, dummy cycles and
// a data phase of req_len+1 bytes, each received byte delivered as a one-cycle strobe.
module qspi_rd_master #(
    parameter int         CLK_DIV      = 4,
    parameter logic [7:0] CMD          = 8'h0B,
    parameter int         DUMMY_CYCLES = 8,
    parameter int         LEN_W        = 8
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    qspi_rd_master_if.slave   host,
    output logic              qspi_clk,
    output logic              qspi_csn,
    output logic              qspi_di,
    input  logic              qspi_do,
    output logic              qspi_wpn,
    output logic              qspi_holdn
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_CMD   = 3'd2,
        S_ADDR  = 3'd3,
        S_DUMMY = 3'd4,
        S_DATA  = 3'd5,
        S_HOLD  = 3'd6,
        S_GAP   = 3'd7
    } state_t;

    localparam logic [7:0]     DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0]     DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
    localparam logic [LEN_W:0] BYTE_ONE   = (LEN_W+1)'(1);

    state_t         state_r, state_nxt;
    logic [7:0]     div_r, div_nxt;
    logic           hi_r, hi_nxt;
    logic [7:0]     bit_r, bit_nxt;
    logic [LEN_W:0] byte_cnt_r, byte_cnt_nxt;
    logic [23:0]    addr_r, addr_nxt;
    logic [7:0]     shift_r, shift_nxt;
    logic [7:0]     rd_byte_r, rd_byte_nxt;
    logic           rd_valid_r, rd_valid_nxt;
    logic           clk_r, csn_r, di_r, ready_r, busy_r, done_r;
    logic           clk_nxt, csn_nxt, di_nxt, ready_nxt, busy_nxt, done_nxt;
    logic           div_last_s, sample_s;

    assign div_last_s = (div_r == DIV_LAST);
    // The rising-edge cycle of SCLK is the first cycle of the high half.
    assign sample_s   = (state_r inside {S_CMD, S_ADDR, S_DUMMY, S_DATA}) && hi_r && (div_r == 8'd0);

    // Next-state logic: half-period divider, bit counter per phase, byte counter.
    always_comb begin
        state_nxt    = state_r;
        div_nxt      = div_r;
        hi_nxt       = hi_r;
        bit_nxt      = bit_r;
        byte_cnt_nxt = byte_cnt_r;
        addr_nxt     = addr_r;
        shift_nxt    = shift_r;
        rd_byte_nxt  = rd_byte_r;
        rd_valid_nxt = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (host.req_valid) begin
                    state_nxt    = S_SETUP;
                    div_nxt      = 8'd0;
                    hi_nxt       = 1'b0;
                    addr_nxt     = host.req_addr;
                    byte_cnt_nxt = {1'b0, host.req_len} + BYTE_ONE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_SETUP: begin
                if (div_last_s) begin
                    state_nxt = S_CMD;
                    div_nxt   = 8'd0;
                    hi_nxt    = 1'b0;
                    bit_nxt   = 8'd7;
                end else begin
                    div_nxt = div_r + 8'd1;
                end
            end
            S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                if (sample_s && (state_r == S_DATA)) begin
                    shift_nxt = {shift_r[6:0], qspi_do};
                    if (bit_r == 8'd0) begin
                        rd_byte_nxt  = {shift_r[6:0], qspi_do};
                        rd_valid_nxt = 1'b1;
                    end else begin
                        rd_valid_nxt = 1'b0;
                    end
                end else begin
                    shift_nxt = shift_r;
                end
                if (!div_last_s) begin
                    div_nxt = div_r + 8'd1;
                end else if (!hi_r) begin
                    div_nxt = 8'd0;
                    hi_nxt  = 1'b1;
                end else begin
                    div_nxt = 8'd0;
                    hi_nxt  = 1'b0;
                    if (bit_r != 8'd0) begin
                        bit_nxt = bit_r - 8'd1;
                    end else begin
                        case (state_r)
                            S_CMD: begin
                                state_nxt = S_ADDR;
                                bit_nxt   = 8'd23;
                            end
                            S_ADDR: begin
                                if (DUMMY_CYCLES > 0) begin
                                    state_nxt = S_DUMMY;
                                    bit_nxt   = DUMMY_LAST;
                                end else begin
                                    state_nxt = S_DATA;
                                    bit_nxt   = 8'd7;
                                end
                            end
                            S_DUMMY: begin
                                state_nxt = S_DATA;
                                bit_nxt   = 8'd7;
                            end
                            S_DATA: begin
                                if (byte_cnt_r == BYTE_ONE) begin
                                    state_nxt = S_HOLD;
                                end else begin
                                    byte_cnt_nxt = byte_cnt_r - BYTE_ONE;
                                    bit_nxt      = 8'd7;
                                end
                            end
                            default: state_nxt = S_IDLE;
                        endcase
                    end
                end
            end
            S_HOLD: begin
                if (div_last_s) begin
                    state_nxt = S_GAP;
                    div_nxt   = 8'd0;
                end else begin
                    div_nxt = div_r + 8'd1;
                end
            end
            S_GAP: begin
                if (div_last_s) begin
                    state_nxt = S_IDLE;
                    div_nxt   = 8'd0;
                end else begin
                    div_nxt = div_r + 8'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output values are decoded from the next state so every pin is a flop.
    always_comb begin
        clk_nxt   = (state_nxt inside {S_CMD, S_ADDR, S_DUMMY, S_DATA}) && hi_nxt;
        csn_nxt   = !(state_nxt inside {S_SETUP, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_HOLD});
        ready_nxt = (state_nxt == S_IDLE);
        busy_nxt  = (state_nxt != S_IDLE) && (state_nxt != S_GAP);
        done_nxt  = (state_nxt == S_GAP) && (state_r != S_GAP);
        case (state_nxt)
            S_CMD:   di_nxt = CMD[bit_nxt[2:0]];
            S_ADDR:  di_nxt = addr_nxt[bit_nxt[4:0]];
            default: di_nxt = 1'b0;
        endcase
    end

    // FSM and datapath state registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            div_r      <= 8'd0;
            hi_r       <= 1'b0;
            bit_r      <= 8'd0;
            byte_cnt_r <= {(LEN_W+1){1'b0}};
            addr_r     <= 24'd0;
            shift_r    <= 8'd0;
        end else begin
            state_r    <= state_nxt;
            div_r      <= div_nxt;
            hi_r       <= hi_nxt;
            bit_r      <= bit_nxt;
            byte_cnt_r <= byte_cnt_nxt;
            addr_r     <= addr_nxt;
            shift_r    <= shift_nxt;
        end
    end

    // Registered pins and host-side status.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_r      <= 1'b0;
            csn_r      <= 1'b1;
            di_r       <= 1'b0;
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rd_byte_r  <= 8'd0;
            rd_valid_r <= 1'b0;
        end else begin
            clk_r      <= clk_nxt;
            csn_r      <= csn_nxt;
            di_r       <= di_nxt;
            ready_r    <= ready_nxt;
            busy_r     <= busy_nxt;
            done_r     <= done_nxt;
            rd_byte_r  <= rd_byte_nxt;
            rd_valid_r <= rd_valid_nxt;
        end
    end

    assign qspi_clk           = clk_r;
    assign qspi_csn           = csn_r;
    assign qspi_di            = di_r;
    assign qspi_wpn           = 1'b1;
    assign qspi_holdn         = 1'b1;
    assign host.req_ready     = ready_r;
    assign host.busy          = busy_r;
    assign host.done          = done_r;
    assign host.rd_byte       = rd_byte_r;
    assign host.rd_byte_valid = rd_valid_r;

endmodule

// File: doc/qspi_rd_master.md
# qspi_rd_master

Single-lane SPI/QSPI-bus read initiator, clocked from one system clock. It generates serial clock, chip select and command/address bits toward the qspi2sdram slave, and samples the returned read data. It turns a parallel request (24-bit address plus byte count) into one fast-read transaction (command, address, dummy cycles, data phase). Each received byte is delivered as a one-cycle strobe. It serves as the board-side/test-side driver for the QSPI-to-SDRAM read path.

## Interface
- CLK_DIV, 4, sys_clk cycles per SCLK half-period; legal range 1..255
- CMD, 8'h0B, read opcode shifted first, MSB first
- DUMMY_CYCLES, 8, SCLK cycles between address and data phase; 0 allowed
- LEN_W, 8, width of req_len
- sys_clk  in  1  system clock. One clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request strobe, taken when req_ready=1
- req_ready  out  1  high only in IDLE
- req_addr  in  24  SDRAM byte address, sent MSB first
- req_len  in  LEN_W  byte count minus 1 (N means N+1 bytes)
- busy  out  1  high from accept until done
- done  out  1  one-cycle pulse at transaction end
- rd_byte  out  8  received byte, MSB first on wire
- rd_byte_valid  out  1  one-cycle strobe, no backpressure
- qspi_clk  out  1  SCLK, mode 0 (idles low)
- qspi_csn  out  1  chip select, active low
- qspi_di  out  1  MOSI to slave
- qspi_do  in  1  MISO from slave
- qspi_wpn  out  1  tied 1
- qspi_holdn  out  1  tied 1

## Operation
- FSM states:
  - IDLE: accept a request, then go to SETUP
  - SETUP: csn low for CLK_DIV cycles, SCLK low; then CMD
  - CMD: 8 bits
  - ADDR: 24 bits
  - DUMMY: DUMMY_CYCLES bits; skipped if 0
  - DATA: 8*(req_len+1) bits
  - HOLD: CLK_DIV cycles with SCLK low and csn low
  - GAP: csn high for CLK_DIV cycles; then IDLE
- On accept, req_addr and req_len are latched; later input changes have no effect.
- Bit cell: SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - qspi_di is updated on the first cycle of the low phase.
  - qspi_do is registered in the cycle where qspi_clk rises.
- qspi_di is 0 during DUMMY and DATA.
- Bit counter counts down per phase. The data byte count is LEN_W+1 bits wide, so req_len = all-ones gives 2^LEN_W bytes with no wrap.
- The byte shift register fills MSB first. After the 8th sample, rd_byte is loaded and rd_byte_valid pulses on the next cycle.
- done pulses on the cycle csn returns high (entry to GAP). busy falls on the same cycle. req_ready rises on entry to IDLE.
- req_valid outside IDLE is ignored and never queued.
- Reset, including mid-transaction, forces the FSM to IDLE immediately. An aborted transaction produces no done and no further strobes.
- Reset values:
  - qspi_csn=1, qspi_clk=0, qspi_di=0, qspi_wpn=1, qspi_holdn=1
  - req_ready=1, busy=0, done=0, rd_byte=0, rd_byte_valid=0

## Timing
- Accept at cycle 0 (req_valid & req_ready): qspi_csn=0, busy=1 and req_ready=0 from cycle 1. The first SCLK rising edge is at cycle 1+2*CLK_DIV.
- csn low duration = (8+24+DUMMY_CYCLES+8*(len+1))*2*CLK_DIV + CLK_DIV + CLK_DIV cycles (setup + bits + hold).
- Minimum csn high between transactions: CLK_DIV cycles plus 1 IDLE cycle.
- rd_byte_valid lag: 1 cycle after the SCLK rising edge carrying bit 0 of each byte.
- Consecutive rd_byte_valid pulses are 16*CLK_DIV cycles apart.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset idle: hold rst_n=0, then release. Required: csn=1, clk=0, req_ready=1, busy=0 for 100 cycles with req_valid=0.
- Basic read (CLK_DIV=2, DUMMY=8), req_addr=24'h123456, req_len=1, slave model returns A5,3C. Required:
  - MOSI stream 0x0B,0x12,0x34,0x56, then 24 zero bits
  - rd_byte A5 then 3C, strobes 32 cycles apart
  - csn low 228 cycles
  - exactly one done pulse
- Max length: req_len=8'hFF. Required: exactly 256 rd_byte_valid pulses with data matching an incrementing-pattern model, then done.
- DUMMY_CYCLES=0, CLK_DIV=1: the data phase starts immediately after address bit 0. Required: the slave sees 32 rising edges before the first data bit.
- Busy rejection: pulse req_valid with addr 24'hABCDEF mid-transaction. Required: no effect on the in-flight MOSI stream, and no second transaction after done.
- Reset mid-DATA: assert rst_n low after 1 byte received. Required:
  - csn=1 asynchronously, no done pulse
  - a new request after release runs a full, correct transaction
